// File: rtl/sgd_x_rd_pkg.sv
// Shared definitions for the x BRAM read side.
//   - bank/engine geometry (S = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH)
//   - BRAM chunk address depth and per-chunk data width
//   - FSM state encoding and the chunk-count helper
package sgd_x_rd_pkg;

    localparam int unsigned BIT_WIDTH_OF_BANK  = 4;
    localparam int unsigned ENGINE_NUM_WIDTH   = 3;
    localparam int unsigned S                  = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
    localparam int unsigned NUM_OF_BANKS       = 8;
    localparam int unsigned NUM_OF_BANKS_WIDTH = 3;
    localparam int unsigned NUM_BITS_PER_BANK  = 4;
    localparam int unsigned DIS_X_BIT_DEPTH    = 10;
    localparam int unsigned MAX_BIT_WIDTH_OF_X = 32;
    localparam int unsigned X_DATA_W           = NUM_BITS_PER_BANK * 32;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStarting = 3'd1,
        StEpoch    = 3'd2,
        StWait     = 3'd3,
        StRead     = 3'd4,
        StFinish   = 3'd5
    } x_rd_state_e;

    // Number of model chunks per pass: dimension rounded up to a multiple of 2^S.
    function automatic logic [31:0] chunks_of(input logic [31:0] dim);
        return (dim >> S) + {31'd0, |dim[S-1:0]};
    endfunction

endpackage

// File: rtl/sgd_x_rd_delay.sv
// Fixed-latency shift register with synchronous active-low reset.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   din         value entering the pipe
//   dout        din delayed by LATENCY cycles (LATENCY >= 1)
module sgd_x_rd_delay #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[LATENCY-1];

endmodule

// File: rtl/sgd_x_rd.sv
// Model-read side of the distributed x BRAM. For every writer credit it runs one
// pass of chunk reads over the model (one bank-group of NUM_OF_BANKS samples) and
// forwards the BRAM data to the ax pipeline tagged with valid/last.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   started                    level start (registered twice before use)
//   dimension, number_of_epochs, number_of_samples, mini_batch_size  job parameters
//   x_wr_credit_counter        writer's cumulative credit count (mod 256)
//   x_rd_ready                 downstream can take a beat RD_LATENCY cycles later
//   x_rd_en, x_rd_addr         BRAM read request
//   x_rd_data_in               BRAM read data, valid RD_LATENCY cycles after x_rd_en
//   x_rd_valid, x_rd_data, x_rd_last  beat to the ax pipeline
//   x_rd_credit_counter        credits consumed (mod 256)
//   sgd_x_rd_done, sgd_x_rd_error     completion / sticky parameter error
//   state_counters_x_rd        debug {x_rd_en, state, sample_index[19:0], epoch_index[7:0]}
//   stall_cycles               credit/ready stall count, built only when
//                              SGD_X_RD_STALL_CNT_EN is defined (else tied to 0)
module sgd_x_rd
    import sgd_x_rd_pkg::*;
#(
    parameter int unsigned RD_LATENCY         = 2,
    parameter int unsigned MAX_DIMENSION_BITS = MAX_BIT_WIDTH_OF_X
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       started,
    input  logic [31:0]                dimension,
    input  logic [31:0]                number_of_epochs,
    input  logic [31:0]                number_of_samples,
    input  logic [31:0]                mini_batch_size,
    input  logic [7:0]                 x_wr_credit_counter,
    input  logic                       x_rd_ready,
    output logic                       x_rd_en,
    output logic [DIS_X_BIT_DEPTH-1:0] x_rd_addr,
    input  logic [X_DATA_W-1:0]        x_rd_data_in,
    output logic                       x_rd_valid,
    output logic [X_DATA_W-1:0]        x_rd_data,
    output logic                       x_rd_last,
    output logic [7:0]                 x_rd_credit_counter,
    output logic                       sgd_x_rd_done,
    output logic                       sgd_x_rd_error,
    output logic [31:0]                state_counters_x_rd,
    output logic [31:0]                stall_cycles
);

    localparam logic [MAX_DIMENSION_BITS-1:0] CHUNK_ONE = 1;

    // Parameter stage 1 (raw) and stage 2 (derived)
    logic [31:0] dimension_r1, epochs_r1, samples_r1;
    logic [7:0]  batch_r1;
    logic [MAX_DIMENSION_BITS-1:0] main_counter;
    logic [31:0] num_epochs, num_samples;
    logic [7:0]  bank_batch_size;
    logic        started_r1, started_r2;
    logic [7:0]  wr_credit_r;

    x_rd_state_e state_q, state_d;
    logic [31:0] epoch_q, epoch_d, sample_q, sample_d;
    logic [MAX_DIMENSION_BITS-1:0] chunk_q, chunk_d;
    logic [7:0]  credit_q, credit_d;
    logic        done_q, done_d, error_q, error_d;
    logic        rd_en, rd_last, credit_avail;
    logic [1:0]  tag_out;

    // Batch size only sizes the writer's batches; reads are paced purely by credits.
    logic unused_batch_bits;
    assign unused_batch_bits = ^{mini_batch_size[31:NUM_OF_BANKS_WIDTH+8],
                                 mini_batch_size[NUM_OF_BANKS_WIDTH-1:0], bank_batch_size};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dimension_r1    <= '0;
            epochs_r1       <= '0;
            samples_r1      <= '0;
            batch_r1        <= '0;
            main_counter    <= '0;
            num_epochs      <= '0;
            num_samples     <= '0;
            bank_batch_size <= '0;
            started_r1      <= 1'b0;
            started_r2      <= 1'b0;
            wr_credit_r     <= '0;
        end else begin
            dimension_r1    <= dimension;
            epochs_r1       <= number_of_epochs;
            samples_r1      <= number_of_samples;
            batch_r1        <= mini_batch_size[NUM_OF_BANKS_WIDTH+7:NUM_OF_BANKS_WIDTH];
            main_counter    <= MAX_DIMENSION_BITS'(chunks_of(dimension_r1));
            num_epochs      <= epochs_r1;
            num_samples     <= samples_r1;
            bank_batch_size <= batch_r1;
            started_r1      <= started;
            started_r2      <= started_r1;
            wr_credit_r     <= x_wr_credit_counter;
        end
    end

    // Modular difference makes the 255 -> 0 wrap transparent.
    assign credit_avail = (wr_credit_r - credit_q) != 8'd0;

    always_comb begin
        state_d  = state_q;
        epoch_d  = epoch_q;
        sample_d = sample_q;
        chunk_d  = chunk_q;
        credit_d = credit_q;
        done_d   = done_q;
        error_d  = error_q;
        rd_en    = 1'b0;
        rd_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (started_r2) state_d = StStarting;
            end
            StStarting: begin
                epoch_d  = '0;
                credit_d = '0;
                done_d   = 1'b0;
                error_d  = 1'b0;
                if (main_counter == '0) begin
                    error_d = 1'b1;
                    state_d = StFinish;
                end else begin
                    state_d = StEpoch;
                end
            end
            StEpoch: begin
                sample_d = '0;
                if (epoch_q == num_epochs) begin
                    state_d = StFinish;
                end else begin
                    epoch_d = epoch_q + 32'd1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sample_q == num_samples) begin
                    state_d = StEpoch;
                end else if (credit_avail) begin
                    credit_d = credit_q + 8'd1;
                    chunk_d  = '0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                if (x_rd_ready) begin
                    rd_en   = 1'b1;
                    chunk_d = chunk_q + CHUNK_ONE;
                    if (chunk_q == main_counter - CHUNK_ONE) begin
                        rd_last  = 1'b1;
                        sample_d = sample_q + 32'(NUM_OF_BANKS);
                        state_d  = StWait;
                    end
                end
            end
            StFinish: begin
                done_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            epoch_q  <= '0;
            sample_q <= '0;
            chunk_q  <= '0;
            credit_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            epoch_q  <= epoch_d;
            sample_q <= sample_d;
            chunk_q  <= chunk_d;
            credit_q <= credit_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Valid/last follow the read enable through the BRAM latency.
    sgd_x_rd_delay #(
        .LATENCY (RD_LATENCY),
        .WIDTH   (2)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({rd_en, rd_last}),
        .dout  (tag_out)
    );

    assign x_rd_en             = rd_en;
    assign x_rd_addr           = rd_en ? DIS_X_BIT_DEPTH'(chunk_q) : '0;
    assign x_rd_valid          = tag_out[1];
    assign x_rd_last           = tag_out[0];
    assign x_rd_data           = x_rd_valid ? x_rd_data_in : '0;
    assign x_rd_credit_counter = credit_q;
    assign sgd_x_rd_done       = done_q;
    assign sgd_x_rd_error      = error_q;
    assign state_counters_x_rd = {rd_en, state_q, sample_q[19:0], epoch_q[7:0]};

`ifdef SGD_X_RD_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_evt;

    // Only a genuine credit wait counts; a WAIT that is about to close the epoch does not.
    assign stall_evt = (state_q == StWait && sample_q != num_samples && !credit_avail) ||
                       (state_q == StRead && !x_rd_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == StStarting) begin
            stall_q <= '0;
        end else if (stall_evt && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/sgd_x_rd.md
Name: sgd_x_rd

Overview:
Model-read side of the distributed x BRAM, paired with the x writer. It consumes the writer's cumulative credit counter and, per credit, issues one pass of chunk reads over the model for one bank-group of NUM_OF_BANKS samples. It forwards the read data, tagged with valid and last, to the dot-product (ax) pipeline. It tracks epochs and samples identically to the writer and reports its own consumed-credit count and done/error status.

Parameters:
RD_LATENCY, 2, BRAM read latency in cycles from x_rd_en to x_rd_data_in valid.
MAX_DIMENSION_BITS, `MAX_BIT_WIDTH_OF_X, maximum model dimension width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
started  in  1  level start from the control block
dimension  in  32  model dimension (features)
number_of_epochs  in  32  epochs to run
number_of_samples  in  32  samples per epoch
mini_batch_size  in  32  samples per batch (multiple of NUM_OF_BANKS)
x_wr_credit_counter  in  8  writer's cumulative credit count, modulo 256
x_rd_ready  in  1  downstream can absorb one beat RD_LATENCY cycles later
x_rd_en  out  1  BRAM read enable
x_rd_addr  out  `DIS_X_BIT_DEPTH  BRAM chunk address
x_rd_data_in  in  `NUM_BITS_PER_BANK*32  BRAM read data
x_rd_valid  out  1  output beat valid
x_rd_data  out  `NUM_BITS_PER_BANK*32  model chunk to the ax pipeline
x_rd_last  out  1  last chunk of the current bank-group pass
x_rd_credit_counter  out  8  credits consumed, modulo 256
sgd_x_rd_done  out  1  all epochs read
sgd_x_rd_error  out  1  sticky parameter error
state_counters_x_rd  out  32  debug {x_rd_en, state[2:0], sample_index[19:0], epoch_index[7:0]}
stall_cycles  out  32  credit-wait cycle count (optional feature)

Behaviour:
- Reset: all outputs 0; state IDLE; RD_LATENCY valid/last pipeline cleared. In-flight reads at reset are dropped.
- Parameters are registered in two stages:
  - S = `BIT_WIDTH_OF_BANK + `ENGINE_NUM_WIDTH
  - main_counter = dimension[31:S] + (dimension[S-1:0] != 0)
  - bank_batch_size = mini_batch_size[`NUM_OF_BANKS_WIDTH+7:`NUM_OF_BANKS_WIDTH]
- FSM:
  - IDLE: when started_r2 (started delayed 2 cycles), go to STARTING.
  - STARTING: clear epoch_index, x_rd_credit_counter, done and error. If main_counter == 0, set error and go to FINISH; otherwise go to EPOCH.
  - EPOCH: clear sample_index. If epoch_index == numEpochs, go to FINISH. Otherwise increment epoch_index and go to WAIT.
  - WAIT: if sample_index == numSamples, go to EPOCH. Otherwise, when (x_wr_credit_counter - x_rd_credit_counter) mod 256 != 0, increment x_rd_credit_counter, clear chunk index and go to READ. The credit input is sampled through one register, so a credit arriving in cycle t is usable at t+1 at earliest.
  - READ: each cycle x_rd_ready=1, assert x_rd_en with x_rd_addr = chunk index, then increment the index. No read is issued when x_rd_ready=0. On the issue with index == main_counter-1, tag last, add `NUM_OF_BANKS to sample_index and go to WAIT.
  - FINISH: hold sgd_x_rd_done=1 until reset.
- Output timing: x_rd_valid and x_rd_last equal x_rd_en and its last tag delayed RD_LATENCY cycles. x_rd_data = x_rd_data_in, registered zero further cycles.
- Throughput: back-to-back reads at 1 per cycle. Between passes there is a 1-cycle WAIT gap.
- One credit is consumed per bank-group pass, so a batch of bank_batch_size credits consumes bank_batch_size passes.
- Credit difference is unsigned 8-bit modular, so wrap from 255 to 0 is transparent.
- Credit in the same cycle as the READ→WAIT transition: it is honoured in WAIT, with no loss.
- started deasserted mid-run: ignored; only reset aborts.

Optional Feature:
SGD_X_RD_STALL_CNT_EN
- Defined: stall_cycles counts cycles in WAIT with zero available credit, plus READ cycles with x_rd_ready=0. It clears in STARTING and saturates at 2^32-1.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package/defines (sgd_defines.vh): state localparams, S, NUM_OF_BANKS, NUM_OF_BANKS_WIDTH, DIS_X_BIT_DEPTH, NUM_BITS_PER_BANK.
- One sub-module, sgd_x_rd_delay: a parameterised RD_LATENCY shift register for {valid, last} with synchronous reset.

Test Plan:
Bench config: S=7, NUM_OF_BANKS=8, RD_LATENCY=2.
- dimension=256, epochs=1, samples=16, batch=8, credit stepped 0→1→2 → exactly 2 passes, addr 0,1 each, x_rd_last on the 2nd beat, x_rd_credit_counter=2, done within 4 cycles after the last beat.
- Credit held at 0 for 20 cycles after start → no x_rd_en, state stays WAIT, stall_cycles=20 with the macro defined, 0 without.
- dimension=300 (main_counter=3), x_rd_ready toggling 1,0,1,0 → reads at addr 0,1,2 only on ready cycles, valid exactly 2 cycles after each en, data matches BRAM.
- Credit counter preset so x_rd_credit_counter=254, writer steps to 255,0,1 → 3 passes consumed across the wrap, x_rd_credit_counter=1.
- dimension=0 → sgd_x_rd_error=1, done=1, no reads issued.
- Reset asserted mid-READ with 2 reads in flight → next cycle all outputs 0, no x_rd_valid emerges afterwards.
